// File: rtl/rca_pipe.sv
// rca_pipe: pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// WIDTH is split into SEG-bit segments; stage k ripples segment k and registers its
// carry, so the cycle time is set by SEG. Results leave in FIFO order after STAGES cycles.
// Optional feature: define RCA_PIPE_SAT_EN to saturate out_sum to the signed limit
// on overflow; without it the sum wraps modulo 2^WIDTH.

module rca_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / SEG;

  // Per-stage registers: valid, operands carried forward, partial sum, segment carry.
  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0]            c_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] s_q;
  logic                         ovf_q;

  // Per-stage inputs (what each stage would load) and the rippled results.
  logic [STAGES-1:0]            load;
  logic [STAGES-1:0]            src_v;
  logic [STAGES-1:0]            src_c;
  logic [STAGES-1:0][WIDTH-1:0] src_a;
  logic [STAGES-1:0][WIDTH-1:0] src_b;
  logic [STAGES-1:0][WIDTH-1:0] src_s;
  logic [STAGES-1:0][WIDTH-1:0] nxt_s;
  logic [STAGES-1:0]            nxt_c;
  logic                         nxt_ovf;

  // Stall chain: a stage may load when empty or when its contents move on this cycle.
  always_comb begin
    logic down;
    load = '0;
    down = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = ~v_q[k] | down;
      down    = load[k];
    end
  end

  // Stage 0 takes the effective operands; later stages take their predecessor's state.
  always_comb begin
    src_v = '0;
    src_c = '0;
    src_a = '0;
    src_b = '0;
    src_s = '0;
    src_v[0] = in_valid;
    src_a[0] = in_a;
    src_b[0] = in_sub ? ~in_b : in_b;
    src_c[0] = in_sub ? 1'b1 : in_cin;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_c[k] = c_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
    end
  end

  // Each stage ripples only its own segment; the final stage also derives overflow.
  always_comb begin
    logic c;
    logic cmsb;
    int   idx;
    nxt_s   = src_s;
    nxt_c   = '0;
    nxt_ovf = 1'b0;
    cmsb    = 1'b0;
    c       = 1'b0;
    idx     = 0;
    for (int k = 0; k < STAGES; k++) begin
      c = src_c[k];
      for (int i = 0; i < SEG; i++) begin
        idx = k * SEG + i;
        if (idx == WIDTH - 1) cmsb = c;
        nxt_s[k][idx] = src_a[k][idx] ^ src_b[k][idx] ^ c;
        c = (src_a[k][idx] & src_b[k][idx]) | (src_a[k][idx] & c) | (src_b[k][idx] & c);
      end
      nxt_c[k] = c;
    end
    nxt_ovf = cmsb ^ nxt_c[STAGES-1];
`ifdef RCA_PIPE_SAT_EN
    if (nxt_ovf) begin
      nxt_s[STAGES-1] = src_a[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    nxt_s[STAGES-1] = nxt_s[STAGES-1];
`endif
  end

  // Pipeline registers: reset clears every stage, otherwise load when allowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            a_q[k] <= src_a[k];
            b_q[k] <= src_b[k];
            s_q[k] <= nxt_s[k];
            c_q[k] <= nxt_c[k];
          end
        end
      end
      if (load[STAGES-1] && src_v[STAGES-1]) ovf_q <= nxt_ovf;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[STAGES-1];
  assign out_sum   = s_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];
  assign out_ovf   = ovf_q;

  // Operand bits already consumed and the last stage's operand copy have no reader;
  // folding them here keeps the full-vector storage tidy, synthesis drops the logic.
  logic unused_bits;
  assign unused_bits = ^{a_q, b_q, s_q};

endmodule
